// File: rtl/uart_alu_if.sv
// uart_alu_if
// Bundles every signal between uart_alu_ctrl and its surroundings: the UART
// receiver/transmitter strobes and data, and the combinational ALU.
//
// Handshake semantics (no backpressure anywhere):
//   rx_done    1-cycle strobe from the receiver; rx_data valid in that cycle.
//   tx_done    1-cycle strobe from the transmitter after its stop bit.
//   tx_start   1-cycle request to the transmitter; tx_data held until tx_done.
//   alu_result combinational function of alu_a/alu_b/alu_op.
//
// Modports:
//   master  - the controller (drives tx_*, alu_a/b/op, busy, err_*)
//   slave   - the UART/ALU environment (drives rx_*, tx_done, alu_result)
interface uart_alu_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic               rx_done;
    logic [NB_DATA-1:0] rx_data;
    logic               tx_done;
    logic [NB_DATA-1:0] alu_result;
    logic               tx_start;
    logic [NB_DATA-1:0] tx_data;
    logic [NB_DATA-1:0] alu_a;
    logic [NB_DATA-1:0] alu_b;
    logic [NB_OP-1:0]   alu_op;
    logic               busy;
    logic               err_op;
    logic               err_drop;
    logic               err_tmo;

    modport master (
        input  rx_done, rx_data, tx_done, alu_result,
        output tx_start, tx_data, alu_a, alu_b, alu_op,
               busy, err_op, err_drop, err_tmo
    );

    modport slave (
        output rx_done, rx_data, tx_done, alu_result,
        input  tx_start, tx_data, alu_a, alu_b, alu_op,
               busy, err_op, err_drop, err_tmo
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl
// Collects three received bytes (operand A, operand B, opcode), drives the
// external combinational ALU, and sends the result byte back through the
// UART transmitter. Invalid opcodes, bytes arriving while busy and (optionally)
// stalled commands are reported as one-cycle error pulses.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   bus        uart_alu_if.master (rx/tx strobes and data, ALU operands and
//              result, busy, err_op, err_drop, err_tmo)
//   state_dbg  current FSM state encoding (debug)
//
// Optional feature: define UART_ALU_TIMEOUT_EN to abandon a partial command
// when no byte arrives for TIMEOUT cycles while waiting for B or the opcode.
module uart_alu_ctrl #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 10_000_000,
    parameter int NB_TMO  = 24
) (
    input  logic       clk,
    input  logic       reset,
    uart_alu_if.master bus,
    output logic [2:0] state_dbg
);
    if (TIMEOUT >= (1 << NB_TMO)) begin : g_tmo_width_check
        $error("NB_TMO too small for TIMEOUT");
    end

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(8'h20);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(8'h22);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(8'h24);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(8'h25);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(8'h26);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(8'h27);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(8'h03);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(8'h02);

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] alu_a_q, alu_a_d;
    logic [NB_DATA-1:0] alu_b_q, alu_b_d;
    logic [NB_OP-1:0]   alu_op_q, alu_op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               err_op_q, err_op_d;
    logic               err_drop_q, err_drop_d;
    logic               err_tmo_q, err_tmo_d;
    logic               op_valid;
    logic               tmo_expired;

    // The whole received byte must match; upper bits outside the opcode field
    // have to be zero.
    always_comb begin
        op_valid = 1'b0;
        if (bus.rx_data[NB_DATA-1:NB_OP] == '0) begin
            case (bus.rx_data[NB_OP-1:0])
                OP_ADD, OP_SUB, OP_AND, OP_OR,
                OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_valid = 1'b1;
                default:                        op_valid = 1'b0;
            endcase
        end
    end

`ifdef UART_ALU_TIMEOUT_EN
    logic [NB_TMO-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counts idle cycles while a command is partially received. A byte in the
    // expiry cycle wins, so rx_done both clears the count and masks expiry.
    always_comb begin
        tmo_cnt_d   = '0;
        tmo_expired = 1'b0;
        if ((state_q == S_WAIT_B || state_q == S_WAIT_OP) && !bus.rx_done) begin
            if (tmo_cnt_q == NB_TMO'(TIMEOUT - 1)) begin
                tmo_expired = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + NB_TMO'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        err_op_d   = 1'b0;
        err_drop_d = 1'b0;
        err_tmo_d  = 1'b0;
        case (state_q)
            S_WAIT_A: begin
                if (bus.rx_done) begin
                    alu_a_d = bus.rx_data;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (bus.rx_done) begin
                    alu_b_d = bus.rx_data;
                    state_d = S_WAIT_OP;
                end else if (tmo_expired) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_WAIT_A;
                end
            end
            S_WAIT_OP: begin
                if (bus.rx_done) begin
                    alu_op_d = bus.rx_data[NB_OP-1:0];
                    if (op_valid) begin
                        state_d = S_EXEC;
                    end else begin
                        err_op_d = 1'b1;
                        state_d  = S_WAIT_A;
                    end
                end else if (tmo_expired) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_WAIT_A;
                end
            end
            S_EXEC: begin
                // ALU has had one full cycle to settle on the new alu_op_q.
                tx_data_d  = bus.alu_result;
                tx_start_d = 1'b1;
                err_drop_d = bus.rx_done;
                state_d    = S_SEND;
            end
            S_SEND: begin
                err_drop_d = bus.rx_done;
                state_d    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                err_drop_d = bus.rx_done;
                if (bus.tx_done) state_d = S_WAIT_A;
            end
            default: state_d = S_WAIT_A;
        endcase
        busy_d = (state_d == S_EXEC) || (state_d == S_SEND) || (state_d == S_WAIT_TX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_op_q   <= 1'b0;
            err_drop_q <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            err_op_q   <= err_op_d;
            err_drop_q <= err_drop_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_op   = alu_op_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;
    assign bus.err_op   = err_op_q;
    assign bus.err_drop = err_drop_q;
    assign bus.err_tmo  = err_tmo_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb_uart_alu_ctrl
// Drives byte streams into uart_alu_ctrl, models the ALU, and checks every
// transmitted result and error pulse (value and cycle) against a reference
// model built from the command rules. Compile with UART_ALU_TIMEOUT_EN
// defined to also exercise the inter-byte timeout (TIMEOUT = 100).
`timescale 1ns/1ps
module tb_uart_alu_ctrl;
    localparam int W   = 8;
    localparam int TMO = 100;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] state_dbg;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_alu_if #(.NB_DATA(W), .NB_OP(6)) bus ();

    uart_alu_ctrl #(.NB_DATA(W), .NB_OP(6), .TIMEOUT(TMO), .NB_TMO(24)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // ---------------- reference ALU ----------------
    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [7:0] op);
        case (op)
            8'h20:   return a + b;
            8'h22:   return a - b;
            8'h24:   return a & b;
            8'h25:   return a | b;
            8'h26:   return a ^ b;
            8'h27:   return ~(a | b);
            8'h03:   return W'($signed(a) >>> b);
            8'h02:   return a >> b;
            default: return '0;
        endcase
    endfunction

    function automatic bit op_ok(input logic [7:0] op);
        return op inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    endfunction

    // The environment's combinational ALU.
    assign bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, {2'b00, bus.alu_op});

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           exp_tx_cyc[$];
    int           exp_op_cyc[$];
    int           exp_drop_cyc[$];
    int           exp_tmo_cyc[$];
    int           checks = 0;
    int           passed = 0;
    bit           mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic pop_cyc(input string name, inout int q[$]);
        if (q.size() == 0) check({name, "_unexpected"}, 1, 0);
        else check({name, "_cycle"}, cyc, q.pop_front());
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (bus.tx_start) begin
                if (exp_q.size() == 0) begin
                    check("tx_start_unexpected", 1, 0);
                end else begin
                    check("tx_data", int'(bus.tx_data), int'(exp_q.pop_front()));
                    check("tx_start_cycle", cyc, exp_tx_cyc.pop_front());
                end
            end
            if (bus.err_op)   pop_cyc("err_op", exp_op_cyc);
            if (bus.err_drop) pop_cyc("err_drop", exp_drop_cyc);
            if (bus.err_tmo)  pop_cyc("err_tmo", exp_tmo_cyc);
        end
    end

    // ---------------- reference model ----------------
    // pend holds the bytes of the command being assembled; m_busy is set from
    // a valid opcode until the transmitter reports completion.
    logic [W-1:0] pend[$];
    bit           m_busy = 1'b0;
    int           m_op_ev = 0;
    int           m_last_ev = 0;

    task automatic model_tmo(input int ev);
`ifdef UART_ALU_TIMEOUT_EN
        if (pend.size() != 0 && ev - m_last_ev > TMO) begin
            exp_tmo_cyc.push_back(m_last_ev + TMO + 1);
            pend.delete();
        end
`else
        if (ev < 0) $display("negative cycle %0d", ev);
`endif
    endtask

    task automatic model_byte(input int ev, input logic [W-1:0] d);
        if (m_busy) begin
            exp_drop_cyc.push_back(ev + 1);
        end else begin
            pend.push_back(d);
            m_last_ev = ev;
            if (pend.size() == 3) begin
                if (op_ok(pend[2])) begin
                    exp_q.push_back(alu_ref(pend[0], pend[1], pend[2]));
                    exp_tx_cyc.push_back(ev + 2);
                    m_busy  = 1'b1;
                    m_op_ev = ev;
                end else begin
                    exp_op_cyc.push_back(ev + 1);
                end
                pend.delete();
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; presents inputs for one cycle.
    task automatic tick(input bit rx, input logic [W-1:0] d, input bit txd);
        int ev;
        ev = cyc;
        model_tmo(ev);
        bus.rx_done = rx;
        bus.rx_data = d;
        bus.tx_done = txd;
        if (rx) model_byte(ev, d);
        // Transmitter completion only counts once the result has been sent.
        if (txd && m_busy && ev >= m_op_ev + 3) m_busy = 1'b0;
        @(negedge clk);
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, '0, 1'b0);
    endtask

    task automatic send(input logic [W-1:0] d);
        tick(1'b1, d, 1'b0);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick(1'b0, '0, $urandom_range(0, 3) == 0);
    endtask

    task automatic finish_tx(input int extra);
        int n;
        n = m_op_ev + 3 + extra - cyc;
        if (n > 0) idle(n);
        tick($urandom_range(0, 3) == 0, W'($urandom), 1'b1);
    endtask

    task automatic cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] op);
        send(a);
        send(b);
        send(op);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] valid_ops[8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    logic [7:0] ra, rb, rop;

    initial begin
        bus.rx_done = 1'b0;
        bus.rx_data = '0;
        bus.tx_done = 1'b0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_tx_start", int'(bus.tx_start), 0);
        check("rst_busy",     int'(bus.busy), 0);
        check("rst_err_op",   int'(bus.err_op), 0);
        check("rst_err_drop", int'(bus.err_drop), 0);
        check("rst_err_tmo",  int'(bus.err_tmo), 0);
        check("rst_tx_data",  int'(bus.tx_data), 0);
        check("rst_alu_a",    int'(bus.alu_a), 0);
        check("rst_alu_b",    int'(bus.alu_b), 0);
        check("rst_alu_op",   int'(bus.alu_op), 0);
        check("rst_state",    int'(state_dbg), 0);

        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // ADD 5+3 = 8, busy right after the opcode, idle again after tx_done.
        cmd(8'h05, 8'h03, 8'h20);
        check("busy_after_op", int'(bus.busy), 1);
        finish_tx(0);
        check("busy_after_tx_done", int'(bus.busy), 0);

        // Back-to-back: SUB 3-5 = 0xFE, then SRA 0xF0>>>2 = 0xFC.
        cmd(8'h03, 8'h05, 8'h22);
        finish_tx(0);
        cmd(8'hF0, 8'h02, 8'h03);
        finish_tx(2);

        // Invalid opcodes: unknown low bits, and valid low bits with upper bits set.
        cmd(8'h01, 8'h02, 8'h3F);
        cmd(8'h01, 8'h02, 8'h60);
        send(8'h77);
        check("alu_a_after_err_op", int'(bus.alu_a), 'h77);
        send(8'h01);
        send(8'h20);
        finish_tx(1);

        // Byte during WAIT_TX is dropped and tx_data holds.
        cmd(8'h05, 8'h03, 8'h20);
        idle(3);
        send(8'hAA);
        idle(1);
        check("tx_data_hold_on_drop", int'(bus.tx_data), 'h08);
        finish_tx(0);
        cmd(8'h09, 8'h04, 8'h25);
        finish_tx(0);

`ifdef UART_ALU_TIMEOUT_EN
        // Gap of exactly TIMEOUT cycles between bytes is still accepted.
        send(8'h10);
        idle(TMO - 1);
        send(8'h20);
        idle(TMO - 1);
        send(8'h20);
        finish_tx(0);
        // One cycle more abandons the command; the late byte becomes A.
        send(8'h10);
        idle(TMO);
        send(8'h33);
        check("alu_a_after_tmo", int'(bus.alu_a), 'h33);
        send(8'h01);
        send(8'h20);
        finish_tx(0);
`else
        // Without the timeout the controller waits indefinitely.
        send(8'h11);
        idle(300);
        check("no_tmo_pulse", int'(bus.err_tmo), 0);
        send(8'h22);
        send(8'h26);
        finish_tx(0);
`endif

        // Reset while the transmit request is high.
        cmd(8'h05, 8'h03, 8'h20);
        tick(1'b0, '0, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_tx_start", int'(bus.tx_start), 0);
        check("rst_mid_busy",     int'(bus.busy), 0);
        check("rst_mid_tx_data",  int'(bus.tx_data), 0);
        check("rst_mid_alu_a",    int'(bus.alu_a), 0);
        check("rst_mid_state",    int'(state_dbg), 0);
        pend.delete();
        m_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tick(1'b0, '0, 1'b1);
        check("late_tx_done_state", int'(state_dbg), 0);
        cmd(8'h0C, 8'h05, 8'h24);
        finish_tx(0);

        // Randomized commands with drops, spurious tx_done and bad opcodes.
        for (int i = 0; i < 150; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = ($urandom_range(0, 9) < 8) ? valid_ops[$urandom_range(0, 7)] : 8'($urandom);
            send(ra);
            gap();
            send(rb);
            gap();
            send(rop);
            if (m_busy) begin
                repeat ($urandom_range(0, 5)) tick($urandom_range(0, 2) == 0, W'($urandom), 1'b0);
                finish_tx($urandom_range(0, 2));
            end
        end

        idle(5);
        check("tx_queue_drained",   exp_q.size(), 0);
        check("op_queue_drained",   exp_op_cyc.size(), 0);
        check("drop_queue_drained", exp_drop_cyc.size(), 0);
        check("tmo_queue_drained",  exp_tmo_cyc.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
